// File: rtl/rgb_fit_unpack.sv
// Captures one rgb_fit frame into a line RAM, then replays each pixel as R,G,B bytes on a 4-phase slot grid.
// Optional feature: define RGB_UNPACK_CKSUM_EN to append a mod-256 checksum slot after the last pixel.
module rgb_fit_unpack #(
    parameter int PIX_NUM    = 240,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [ADDR_WIDTH-1:0] rgb_fit_addr,
    input  logic                  rgb_fit_valid,
    input  logic                  sync_rgb_fit,
    input  logic [23:0]           rgb_fit_in,
    input  logic                  tx_en,
    output logic [7:0]            uphi_tx_vol,
    output logic                  uphi_tx_valid,
    output logic [1:0]            uphi_tx_phase,
    output logic                  buf_full,
    output logic                  frame_done,
    output logic                  addr_err,
    output logic                  ovf_err
);

    typedef enum logic [2:0] {IDLE, CAPTURE, FULL, SERIAL, DONE} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_PIX = ADDR_WIDTH'(PIX_NUM - 1);

    state_t                state, state_next;
    logic                  sync_d;
    logic [ADDR_WIDTH-1:0] pix_cnt;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [1:0]            slot;
    logic [7:0]            cksum;
    logic [23:0]           rd_data;
    logic [23:0]           ram [PIX_NUM];

    logic       sync_rise, sync_fall;
    logic       capture_last, slot_end, last_pix_b, frame_end;
    logic       ram_we, ram_re, emit;
    logic [7:0] byte_sel;

    always_comb begin
        sync_rise    = sync_rgb_fit && !sync_d;
        sync_fall    = !sync_rgb_fit && sync_d;
        capture_last = (state == CAPTURE) && rgb_fit_valid && (pix_cnt == LAST_PIX);
        slot_end     = (state == SERIAL) && (uphi_tx_phase == 2'd3);
        last_pix_b   = (slot == 2'd2) && (rd_ptr == LAST_PIX);
`ifdef RGB_UNPACK_CKSUM_EN
        frame_end    = slot_end && (slot == 2'd3);
`else
        frame_end    = slot_end && last_pix_b;
`endif
        ram_we = (state == CAPTURE) && rgb_fit_valid &&
                 ({1'b0, rgb_fit_addr} < (ADDR_WIDTH + 1)'(PIX_NUM));
        ram_re = (state == SERIAL) && (uphi_tx_phase == 2'd0) && (slot == 2'd0);
        // Byte is loaded into the output register in phase 2 so it shows in phase 3.
        emit   = (state == SERIAL) && (uphi_tx_phase == 2'd2);
        case (slot)
            2'd0:    byte_sel = rd_data[23:16];
            2'd1:    byte_sel = rd_data[15:8];
            2'd2:    byte_sel = rd_data[7:0];
            default: byte_sel = cksum;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (sync_rise) state_next = CAPTURE;
            CAPTURE: begin
                if (capture_last)   state_next = FULL;
                else if (sync_fall) state_next = IDLE;
            end
            FULL:    if (tx_en) state_next = SERIAL;
            SERIAL:  if (frame_end) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_d        <= 1'b0;
            pix_cnt       <= '0;
            rd_ptr        <= '0;
            slot          <= 2'd0;
            cksum         <= 8'd0;
            uphi_tx_vol   <= 8'd0;
            uphi_tx_valid <= 1'b0;
            uphi_tx_phase <= 2'd0;
            buf_full      <= 1'b0;
            frame_done    <= 1'b0;
            addr_err      <= 1'b0;
            ovf_err       <= 1'b0;
        end else begin
            sync_d        <= sync_rgb_fit;
            uphi_tx_valid <= emit;
            uphi_tx_vol   <= emit ? byte_sel : 8'd0;
            frame_done    <= frame_end;
            if (rgb_fit_valid && state != CAPTURE) ovf_err <= 1'b1;
            case (state)
                IDLE: begin
                    if (sync_rise) begin
                        pix_cnt  <= '0;
                        addr_err <= 1'b0;
                        ovf_err  <= 1'b0;
                    end
                end
                CAPTURE: begin
                    if (rgb_fit_valid) begin
                        if (pix_cnt != LAST_PIX) pix_cnt <= pix_cnt + 1'b1;
                        if (rgb_fit_addr != pix_cnt) addr_err <= 1'b1;
                    end
                    if (capture_last)   buf_full <= 1'b1;
                    else if (sync_fall) addr_err <= 1'b1;
                end
                FULL: begin
                    if (tx_en) begin
                        buf_full      <= 1'b0;
                        rd_ptr        <= '0;
                        slot          <= 2'd0;
                        cksum         <= 8'd0;
                        uphi_tx_phase <= 2'd0;
                    end
                end
                SERIAL: begin
                    // A paused stream parks at phase 0, i.e. between slots.
                    if (uphi_tx_phase != 2'd0 || tx_en) uphi_tx_phase <= uphi_tx_phase + 2'd1;
                    if (emit) cksum <= cksum + byte_sel;
                    if (slot_end) begin
                        if (slot == 2'd2 && !last_pix_b) begin
                            rd_ptr <= rd_ptr + 1'b1;
                            slot   <= 2'd0;
                        end else begin
                            slot <= slot + 2'd1;
                        end
                    end
                end
                DONE:    uphi_tx_phase <= 2'd0;
                default: uphi_tx_phase <= 2'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) ram[rgb_fit_addr] <= rgb_fit_in;
        if (ram_re) rd_data <= ram[rd_ptr];
    end

endmodule
